ttt_referee: RTL and testbench
==============================

// Module: ttt_referee
// PURPOSE
//  Human-side front end of the tic-tac-toe engine interface. Accepts human moves,
//  checks legality against a tracked 3x3 board, forwards legal moves to the engine,
//  and collects the engine's reply. Detects win/draw for either side and flags
//  illegal human moves and faulty engine replies. Sits between the user-input logic
//  and the computer-move FSM.
// PARAMETERS
//  ENG_TIMEOUT  16  max cycles in ENG_REQ waiting for engValidIn before engine fault
// PORTS
//  clock        in   1  system clock
//  reset        in   1  asynchronous, active-high; clears all state
//  newGame      in   1  synchronous clear of board/result, go to IDLE
//  hMoveIn      in   4  human square index, 0..8 row-major (0=top-left)
//  hValid       in   1  hMoveIn valid; accepted when hValid & hReady
//  hReady       out  1  referee can take a human move
//  hMove        out  4  legal human move presented to the engine
//  engValid     out  1  hMove valid; held until engine replies
//  cMove        in   4  engine reply square, 0..8
//  engValidIn   in   1  cMove valid; single-cycle pulse
//  boardX       out  9  squares held by human, bit i = square i
//  boardO       out  9  squares held by computer
//  moveCount    out  4  occupied squares, 0..9
//  illegal      out  1  one-cycle pulse: last human move rejected
//  engErr       out  1  sticky: engine reply bad or timed out
//  gameOver     out  1  game finished (state DONE)
//  result       out  2  00 none, 01 human win, 10 computer win, 11 draw
// BEHAVIOUR
//  - Reset (async): state IDLE; boardX=boardO=0; moveCount=0; hMove=0;
//    engValid=0; illegal=0; engErr=0; result=00; timeout counter 0.
//  - States: IDLE, H_EVAL, ENG_REQ, C_EVAL, DONE. hReady=1 only in IDLE.
//  - IDLE: on hValid at edge N: if hMoveIn>8 or square occupied (X|O),
//    illegal=1 for the cycle after N, board unchanged, stay IDLE. Else set
//    boardX[hMoveIn], moveCount+1, hMove<=hMoveIn, go H_EVAL.
//  - H_EVAL (1 cycle): X holds any of 8 lines (3 rows, 3 cols, 2 diags)
//    -> result=01, DONE; else moveCount==9 -> result=11, DONE; else ENG_REQ.
//  - ENG_REQ: engValid=1, hMove stable. Counter increments each cycle.
//    On engValidIn: cMove>8 or occupied -> engErr=1, DONE, result=00;
//    else set boardO[cMove], moveCount+1, go C_EVAL. Counter reaching
//    ENG_TIMEOUT without engValidIn -> engErr=1, DONE. engValid drops on
//    the edge leaving ENG_REQ. engValidIn outside ENG_REQ is ignored.
//  - C_EVAL (1 cycle): O holds a line -> result=10, DONE; moveCount==9 ->
//    result=11, DONE; else IDLE.
//  - DONE: gameOver=1; board, result, engErr frozen; hValid ignored
//    (hReady=0, no illegal pulse). Leaves only via newGame or reset.
//  - newGame: highest priority after reset, any state; next edge clears board,
//    moveCount, result, engErr, counter, engValid; state IDLE. hValid in the
//    same cycle is dropped.
//  - Only one side can hold a line: evaluation runs after every move.
//  - Latency: accepted human move -> engValid high 2 edges later.
// TESTING
//  - Reset mid-ENG_REQ: assert reset async -> engValid, boards, result 0 at once.
//  - hMoveIn=4 accepted; engine replies cMove=0 -> boardX=0x010, boardO=0x001,
//    moveCount=2, back to IDLE, hReady=1.
//  - Repeat hMoveIn=4 or hMoveIn=12 -> illegal one-cycle pulse, board unchanged.
//  - Human plays 0,1,2 (engine 4,8) -> result=01, gameOver=1, engValid never
//    raised after third move.
//  - Engine replies occupied square, or silent for 16 cycles -> engErr=1,
//    DONE, result=00; newGame -> all cleared, IDLE.
//  - Full board with no line (X:0,2,3,7,8; O:1,4,5,6) -> result=11, moveCount=9.

Source files
------------

// File: rtl/ttt_referee.sv
// Tic-tac-toe referee: validates human moves against the tracked board, hands legal
// moves to the engine, checks the engine's reply and decides win/draw/fault.
module ttt_referee #(
    parameter int ENG_TIMEOUT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       newGame,
    input  logic [3:0] hMoveIn,
    input  logic       hValid,
    output logic       hReady,
    output logic [3:0] hMove,
    output logic       engValid,
    input  logic [3:0] cMove,
    input  logic       engValidIn,
    output logic [8:0] boardX,
    output logic [8:0] boardO,
    output logic [3:0] moveCount,
    output logic       illegal,
    output logic       engErr,
    output logic       gameOver,
    output logic [1:0] result,
    output logic [2:0] dbgState
);

    // Handshakes: a human move transfers on a clock edge where hValid & hReady.
    // engValid/hMove stay asserted and stable until the edge that leaves ENG_REQ;
    // engValidIn is a one-cycle pulse that is only looked at while in ENG_REQ.

    localparam int CW = $clog2(ENG_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_H_EVAL  = 3'd1,
        S_ENG_REQ = 3'd2,
        S_C_EVAL  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [8:0]      boardX_q, boardX_d;
    logic [8:0]      boardO_q, boardO_d;
    logic [3:0]      moveCount_q, moveCount_d;
    logic [3:0]      hMove_q, hMove_d;
    logic            illegal_q, illegal_d;
    logic            engErr_q, engErr_d;
    logic [1:0]      result_q, result_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [8:0] h_mask;
    logic [8:0] c_mask;
    logic       h_bad;
    logic       c_bad;

    function automatic logic has_line(input logic [8:0] b);
        return (&b[2:0]) | (&b[5:3]) | (&b[8:6]) |
               (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
               (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    endfunction

    // Out-of-range indices shift the one-hot mask to zero; the range check rejects them first.
    assign h_mask = 9'd1 << hMoveIn;
    assign c_mask = 9'd1 << cMove;
    assign h_bad  = (hMoveIn > 4'd8) || (|(h_mask & (boardX_q | boardO_q)));
    assign c_bad  = (cMove > 4'd8) || (|(c_mask & (boardX_q | boardO_q)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            boardX_q    <= '0;
            boardO_q    <= '0;
            moveCount_q <= '0;
            hMove_q     <= '0;
            illegal_q   <= 1'b0;
            engErr_q    <= 1'b0;
            result_q    <= 2'b00;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            boardX_q    <= boardX_d;
            boardO_q    <= boardO_d;
            moveCount_q <= moveCount_d;
            hMove_q     <= hMove_d;
            illegal_q   <= illegal_d;
            engErr_q    <= engErr_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        boardX_d    = boardX_q;
        boardO_d    = boardO_q;
        moveCount_d = moveCount_q;
        hMove_d     = hMove_q;
        illegal_d   = 1'b0;
        engErr_d    = engErr_q;
        result_d    = result_q;
        cnt_d       = '0;

        if (newGame) begin
            state_d     = S_IDLE;
            boardX_d    = '0;
            boardO_d    = '0;
            moveCount_d = '0;
            engErr_d    = 1'b0;
            result_d    = 2'b00;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (hValid) begin
                        if (h_bad) begin
                            illegal_d = 1'b1;
                        end else begin
                            boardX_d    = boardX_q | h_mask;
                            moveCount_d = moveCount_q + 4'd1;
                            hMove_d     = hMoveIn;
                            state_d     = S_H_EVAL;
                        end
                    end
                end
                S_H_EVAL: begin
                    if (has_line(boardX_q)) begin
                        result_d = 2'b01;
                        state_d  = S_DONE;
                    end else if (moveCount_q == 4'd9) begin
                        result_d = 2'b11;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_ENG_REQ;
                    end
                end
                S_ENG_REQ: begin
                    cnt_d = cnt_q + CW'(1);
                    if (engValidIn) begin
                        if (c_bad) begin
                            engErr_d = 1'b1;
                            result_d = 2'b00;
                            state_d  = S_DONE;
                        end else begin
                            boardO_d    = boardO_q | c_mask;
                            moveCount_d = moveCount_q + 4'd1;
                            state_d     = S_C_EVAL;
                        end
                    end else if (cnt_q == CW'(ENG_TIMEOUT - 1)) begin
                        // This was the last cycle the engine was allowed to answer in.
                        engErr_d = 1'b1;
                        result_d = 2'b00;
                        state_d  = S_DONE;
                    end
                end
                S_C_EVAL: begin
                    if (has_line(boardO_q)) begin
                        result_d = 2'b10;
                        state_d  = S_DONE;
                    end else if (moveCount_q == 4'd9) begin
                        result_d = 2'b11;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign hReady    = (state_q == S_IDLE);
    assign engValid  = (state_q == S_ENG_REQ);
    assign gameOver  = (state_q == S_DONE);
    assign hMove     = hMove_q;
    assign boardX    = boardX_q;
    assign boardO    = boardO_q;
    assign moveCount = moveCount_q;
    assign illegal   = illegal_q;
    assign engErr    = engErr_q;
    assign result    = result_q;
    assign dbgState  = state_q;

endmodule

// File: tb/tb_ttt_referee.sv
// Bench for ttt_referee: scripted game table, hand-written corner sequences and
// random games checked against a square-array reference model.
module tb_ttt_referee;

    logic       clock = 1'b0;
    logic       reset;
    logic       newGame;
    logic [3:0] hMoveIn;
    logic       hValid;
    logic       hReady;
    logic [3:0] hMove;
    logic       engValid;
    logic [3:0] cMove;
    logic       engValidIn;
    logic [8:0] boardX;
    logic [8:0] boardO;
    logic [3:0] moveCount;
    logic       illegal;
    logic       engErr;
    logic       gameOver;
    logic [1:0] result;
    logic [2:0] dbgState;

    ttt_referee #(.ENG_TIMEOUT(16)) dut (
        .clock(clock), .reset(reset), .newGame(newGame),
        .hMoveIn(hMoveIn), .hValid(hValid), .hReady(hReady),
        .hMove(hMove), .engValid(engValid),
        .cMove(cMove), .engValidIn(engValidIn),
        .boardX(boardX), .boardO(boardO), .moveCount(moveCount),
        .illegal(illegal), .engErr(engErr), .gameOver(gameOver),
        .result(result), .dbgState(dbgState)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // scoreboard
    int total = 0;
    int bad = 0;
    logic [3:0] exp_q[$];

    // reference model: mark[i] 0 empty, 1 human, 2 computer
    int mark[9];
    int nmoves;

    typedef struct {
        bit         ng;
        logic [3:0] h;
        logic [3:0] c;
        logic [8:0] ex;
        logic [8:0] eo;
        logic [3:0] emc;
        logic [1:0] eres;
        bit         ego;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // driver tasks
    task automatic new_game();
        newGame = 1'b1;
        tick();
        newGame = 1'b0;
    endtask

    task automatic human(input logic [3:0] sq);
        hMoveIn = sq;
        hValid  = 1'b1;
        tick();
        hValid  = 1'b0;
    endtask

    task automatic engine(input logic [3:0] sq);
        cMove      = sq;
        engValidIn = 1'b1;
        tick();
        engValidIn = 1'b0;
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 9; i++) mark[i] = 0;
        nmoves = 0;
    endfunction

    function automatic logic [8:0] model_board(input int who);
        logic [8:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) if (mark[i] == who) b[i] = 1'b1;
        return b;
    endfunction

    function automatic bit model_line(input int who);
        bit won;
        won = 0;
        for (int r = 0; r < 3; r++) begin
            if (mark[3*r] == who && mark[3*r+1] == who && mark[3*r+2] == who) won = 1;
            if (mark[r] == who && mark[r+3] == who && mark[r+6] == who) won = 1;
        end
        if (mark[0] == who && mark[4] == who && mark[8] == who) won = 1;
        if (mark[2] == who && mark[4] == who && mark[6] == who) won = 1;
        return won;
    endfunction

    function automatic int pick_empty();
        int k;
        k = $urandom_range(0, 8 - nmoves);
        for (int i = 0; i < 9; i++) begin
            if (mark[i] == 0) begin
                if (k == 0) return i;
                k--;
            end
        end
        return 0;
    endfunction

    function automatic int pick_marked();
        int k;
        k = $urandom_range(0, nmoves - 1);
        for (int i = 0; i < 9; i++) begin
            if (mark[i] != 0) begin
                if (k == 0) return i;
                k--;
            end
        end
        return 0;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, "_boardX"}, 32'(boardX), 32'(model_board(1)));
        chk({tag, "_boardO"}, 32'(boardO), 32'(model_board(2)));
        chk({tag, "_count"}, 32'(moveCount), 32'(nmoves));
    endtask

    task automatic play_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        if (v.ng) new_game();
        human(v.h);
        chk({tag, "_illegal"}, 32'(illegal), 32'd0);
        chk({tag, "_engv_early"}, 32'(engValid), 32'd0);
        tick();
        if (v.c == 4'hF) begin
            chk({tag, "_engv_none"}, 32'(engValid), 32'd0);
        end else begin
            chk({tag, "_engv"}, 32'(engValid), 32'd1);
            chk({tag, "_hmove"}, 32'(hMove), 32'(v.h));
            engine(v.c);
            chk({tag, "_engv_drop"}, 32'(engValid), 32'd0);
            tick();
        end
        chk({tag, "_boardX"}, 32'(boardX), 32'(v.ex));
        chk({tag, "_boardO"}, 32'(boardO), 32'(v.eo));
        chk({tag, "_count"}, 32'(moveCount), 32'(v.emc));
        chk({tag, "_result"}, 32'(result), 32'(v.eres));
        chk({tag, "_over"}, 32'(gameOver), 32'(v.ego));
        chk({tag, "_hready"}, 32'(hReady), 32'(!v.ego));
    endtask

    task automatic random_game(input int g);
        bit over;
        int guard;
        int r;
        int sq;
        int csq;
        int d;
        bit legal;
        logic [3:0] e;
        string tag;
        tag = $sformatf("rnd%0d", g);
        new_game();
        model_clear();
        over = 0;
        guard = 0;
        while (!over && guard < 40) begin
            guard++;
            r = $urandom_range(0, 9);
            if (r < 2) sq = $urandom_range(9, 15);
            else if (r < 4) sq = $urandom_range(0, 8);
            else sq = pick_empty();
            legal = (sq <= 8) && (mark[sq] == 0);
            chk({tag, "_hready"}, 32'(hReady), 32'd1);
            human(4'(sq));
            if (!legal) begin
                chk({tag, "_illegal_hi"}, 32'(illegal), 32'd1);
                tick();
                chk({tag, "_illegal_lo"}, 32'(illegal), 32'd0);
                check_model({tag, "_ill"});
                continue;
            end
            chk({tag, "_illegal_none"}, 32'(illegal), 32'd0);
            mark[sq] = 1;
            nmoves++;
            chk({tag, "_engv_early"}, 32'(engValid), 32'd0);
            tick();
            if (model_line(1) || nmoves == 9) begin
                chk({tag, "_result_h"}, 32'(result), model_line(1) ? 32'd1 : 32'd3);
                chk({tag, "_over_h"}, 32'(gameOver), 32'd1);
                chk({tag, "_engv_none"}, 32'(engValid), 32'd0);
                check_model({tag, "_hend"});
                over = 1;
                continue;
            end
            exp_q.push_back(4'(sq));
            chk({tag, "_engv"}, 32'(engValid), 32'd1);
            e = exp_q.pop_front();
            chk({tag, "_hmove"}, 32'(hMove), 32'(e));
            r = $urandom_range(0, 19);
            if (r == 0) begin
                repeat (15) tick();
                chk({tag, "_to_wait"}, 32'(engValid), 32'd1);
                chk({tag, "_to_noerr"}, 32'(engErr), 32'd0);
                tick();
                chk({tag, "_to_err"}, 32'(engErr), 32'd1);
                chk({tag, "_to_over"}, 32'(gameOver), 32'd1);
                chk({tag, "_to_result"}, 32'(result), 32'd0);
                check_model({tag, "_to"});
                over = 1;
            end else if (r == 1) begin
                csq = ($urandom_range(0, 1) == 0) ? pick_marked() : $urandom_range(9, 15);
                engine(4'(csq));
                chk({tag, "_bad_err"}, 32'(engErr), 32'd1);
                chk({tag, "_bad_over"}, 32'(gameOver), 32'd1);
                chk({tag, "_bad_result"}, 32'(result), 32'd0);
                chk({tag, "_bad_engv"}, 32'(engValid), 32'd0);
                check_model({tag, "_bad"});
                over = 1;
            end else begin
                d = $urandom_range(0, 5);
                repeat (d) tick();
                chk({tag, "_engv_hold"}, 32'(engValid), 32'd1);
                csq = pick_empty();
                engine(4'(csq));
                mark[csq] = 2;
                nmoves++;
                chk({tag, "_engv_drop"}, 32'(engValid), 32'd0);
                tick();
                if (model_line(2) || nmoves == 9) begin
                    chk({tag, "_result_c"}, 32'(result), model_line(2) ? 32'd2 : 32'd3);
                    chk({tag, "_over_c"}, 32'(gameOver), 32'd1);
                    over = 1;
                end else begin
                    chk({tag, "_over_no"}, 32'(gameOver), 32'd0);
                end
                chk({tag, "_err_no"}, 32'(engErr), 32'd0);
                check_model({tag, "_c"});
            end
        end
        if (over) begin
            human(4'($urandom_range(0, 15)));
            chk({tag, "_done_illegal"}, 32'(illegal), 32'd0);
            chk({tag, "_done_over"}, 32'(gameOver), 32'd1);
            chk({tag, "_done_hready"}, 32'(hReady), 32'd0);
            check_model({tag, "_done"});
        end
    endtask

    initial begin
        reset      = 1'b1;
        newGame    = 1'b0;
        hValid     = 1'b0;
        hMoveIn    = 4'd0;
        cMove      = 4'd0;
        engValidIn = 1'b0;

        tbl[0]  = '{1, 4'd4, 4'd0, 9'h010, 9'h001, 4'd2, 2'd0, 0};
        tbl[1]  = '{1, 4'd0, 4'd4, 9'h001, 9'h010, 4'd2, 2'd0, 0};
        tbl[2]  = '{0, 4'd1, 4'd8, 9'h003, 9'h110, 4'd4, 2'd0, 0};
        tbl[3]  = '{0, 4'd2, 4'hF, 9'h007, 9'h110, 4'd5, 2'd1, 1};
        tbl[4]  = '{1, 4'd0, 4'd1, 9'h001, 9'h002, 4'd2, 2'd0, 0};
        tbl[5]  = '{0, 4'd2, 4'd4, 9'h005, 9'h012, 4'd4, 2'd0, 0};
        tbl[6]  = '{0, 4'd3, 4'd5, 9'h00D, 9'h032, 4'd6, 2'd0, 0};
        tbl[7]  = '{0, 4'd7, 4'd6, 9'h08D, 9'h072, 4'd8, 2'd0, 0};
        tbl[8]  = '{0, 4'd8, 4'hF, 9'h18D, 9'h072, 4'd9, 2'd3, 1};
        tbl[9]  = '{1, 4'd0, 4'd4, 9'h001, 9'h010, 4'd2, 2'd0, 0};
        tbl[10] = '{0, 4'd1, 4'd2, 9'h003, 9'h014, 4'd4, 2'd0, 0};
        tbl[11] = '{0, 4'd8, 4'd6, 9'h103, 9'h054, 4'd6, 2'd2, 1};

        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("rst_boardX", 32'(boardX), 32'd0);
        chk("rst_boardO", 32'(boardO), 32'd0);
        chk("rst_count", 32'(moveCount), 32'd0);
        chk("rst_hmove", 32'(hMove), 32'd0);
        chk("rst_engv", 32'(engValid), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_err", 32'(engErr), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_over", 32'(gameOver), 32'd0);
        chk("rst_hready", 32'(hReady), 32'd1);

        for (int i = 0; i < 12; i++) play_vec(tbl[i], i);

        // illegal repeats and out-of-range square
        new_game();
        human(4'd4);
        tick();
        engine(4'd0);
        tick();
        human(4'd4);
        chk("rep4_illegal", 32'(illegal), 32'd1);
        chk("rep4_boardX", 32'(boardX), 32'h010);
        chk("rep4_hready", 32'(hReady), 32'd1);
        tick();
        chk("rep4_pulse_end", 32'(illegal), 32'd0);
        human(4'd12);
        chk("sq12_illegal", 32'(illegal), 32'd1);
        chk("sq12_count", 32'(moveCount), 32'd2);
        tick();
        chk("sq12_pulse_end", 32'(illegal), 32'd0);
        human(4'd0);
        chk("occO_illegal", 32'(illegal), 32'd1);
        tick();

        // engine pulse while idle is ignored
        engine(4'd3);
        chk("idle_eng_boardO", 32'(boardO), 32'h001);
        chk("idle_eng_count", 32'(moveCount), 32'd2);

        // engine answers an occupied square
        human(4'd8);
        tick();
        chk("occ_engv", 32'(engValid), 32'd1);
        engine(4'd4);
        chk("occ_err", 32'(engErr), 32'd1);
        chk("occ_over", 32'(gameOver), 32'd1);
        chk("occ_result", 32'(result), 32'd0);
        chk("occ_boardO", 32'(boardO), 32'h001);
        human(4'd5);
        chk("done_no_illegal", 32'(illegal), 32'd0);
        chk("done_boardX", 32'(boardX), 32'h110);

        // newGame wins over a same-cycle human move
        newGame = 1'b1;
        hValid  = 1'b1;
        hMoveIn = 4'd4;
        tick();
        newGame = 1'b0;
        hValid  = 1'b0;
        chk("ng_boardX", 32'(boardX), 32'd0);
        chk("ng_boardO", 32'(boardO), 32'd0);
        chk("ng_count", 32'(moveCount), 32'd0);
        chk("ng_err", 32'(engErr), 32'd0);
        chk("ng_over", 32'(gameOver), 32'd0);
        chk("ng_hready", 32'(hReady), 32'd1);
        tick();
        chk("ng_dropped", 32'(boardX), 32'd0);

        // silent engine
        human(4'd4);
        tick();
        repeat (15) tick();
        chk("to15_engv", 32'(engValid), 32'd1);
        chk("to15_err", 32'(engErr), 32'd0);
        tick();
        chk("to16_err", 32'(engErr), 32'd1);
        chk("to16_over", 32'(gameOver), 32'd1);
        chk("to16_engv", 32'(engValid), 32'd0);
        chk("to16_result", 32'(result), 32'd0);
        new_game();
        chk("to_clear_err", 32'(engErr), 32'd0);
        chk("to_clear_boardX", 32'(boardX), 32'd0);

        // asynchronous reset in the middle of an engine request
        human(4'd0);
        tick();
        chk("mid_engv", 32'(engValid), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_engv", 32'(engValid), 32'd0);
        chk("arst_boardX", 32'(boardX), 32'd0);
        chk("arst_count", 32'(moveCount), 32'd0);
        chk("arst_result", 32'(result), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("arst_hready", 32'(hReady), 32'd1);

        for (int g = 0; g < 40; g++) random_game(g);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
